// File: rtl/fpu_mul_scheduler.sv
// ---------------------------------------------------------------------------
// fpu_mul_scheduler
//
// Purpose:
//   Lets N_REQ client datapaths share one pipelined single-precision FP
//   multiplier. A round-robin arbiter picks one valid requester per cycle.
//   The winning operands are registered and issued to the multiplier. A tag
//   pipe carries the requester index alongside the operation, so it lines up
//   with mul_result. Each result then lands in a small response FIFO.
//   The arbiter only grants while the in-flight operations plus the queued
//   responses leave room in the FIFO, so a multiplier result never has to be
//   dropped.
//
// Ports:
//   clk_in      - clock, rising edge
//   reset_n     - synchronous, active-low reset (the multiplier shares it)
//   req_valid   - per-requester operation valid
//   req_ready   - per-requester accept, one-hot or zero (combinational)
//   req_a/req_b - packed operands, requester i at [i*D_WIDTH +: D_WIDTH]
//   mul_valid   - registered issue strobe to the multiplier
//   mul_a/mul_b - registered operands to the multiplier
//   mul_result  - multiplier product, MUL_LATENCY cycles after mul_valid
//   rsp_valid   - response FIFO non-empty
//   rsp_ready   - consumer pops the head response
//   rsp_id      - requester index of the head response
//   rsp_data    - product of the head response
//   busy        - any operation in flight or any response queued
// ---------------------------------------------------------------------------
module fpu_mul_scheduler #(
    parameter int D_WIDTH     = 32,
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int MUL_LATENCY = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                       clk_in,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*D_WIDTH-1:0]   req_a,
    input  logic [N_REQ*D_WIDTH-1:0]   req_b,
    output logic                       mul_valid,
    output logic [D_WIDTH-1:0]         mul_a,
    output logic [D_WIDTH-1:0]         mul_b,
    input  logic [D_WIDTH-1:0]         mul_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [D_WIDTH-1:0]         rsp_data,
    output logic                       busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + MUL_LATENCY + 2);

    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                mul_valid_q, mul_valid_d;
    logic [D_WIDTH-1:0]  mul_a_q, mul_a_d;
    logic [D_WIDTH-1:0]  mul_b_q, mul_b_d;
    logic [ID_W-1:0]     issue_id_q, issue_id_d;

    logic [MUL_LATENCY-1:0] tag_valid_q, tag_valid_d;
    logic [ID_W-1:0]        tag_id_q [MUL_LATENCY];
    logic [ID_W-1:0]        tag_id_d [MUL_LATENCY];

    logic [D_WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [D_WIDTH-1:0]  fifo_data_d [FIFO_DEPTH];
    logic [ID_W-1:0]     fifo_id_q   [FIFO_DEPTH];
    logic [ID_W-1:0]     fifo_id_d   [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      fifo_count_q, fifo_count_d;

    logic [CNT_W-1:0]    in_flight;
    logic                credit_ok;
    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic [N_REQ-1:0]    grant_oh;
    logic [D_WIDTH-1:0]  grant_a;
    logic [D_WIDTH-1:0]  grant_b;
    logic                handshake;
    logic                push;
    logic                pop;

    // Operations still owed a FIFO slot: the issue register plus every live
    // tag-pipe stage. A pop in this same cycle deliberately returns no
    // credit. This keeps the credit path free of any dependence on
    // rsp_ready.
    always_comb begin
        in_flight = CNT_W'(mul_valid_q);
        for (int i = 0; i < MUL_LATENCY; i++) begin
            in_flight = in_flight + CNT_W'(tag_valid_q[i]);
        end
        credit_ok = (in_flight + CNT_W'(fifo_count_q)) < CNT_W'(FIFO_DEPTH);
    end

    // Round-robin search in two passes. The first pass covers indices at or
    // above rr_ptr, and the second covers the indices below it. The first
    // valid requester found wins. This gives the wrap-around order without a
    // modulo, so it also works when N_REQ is not a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        grant_a     = '0;
        grant_b     = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!grant_found && req_valid[i] &&
                    ((p == 0) == (i >= int'(rr_ptr_q)))) begin
                    grant_found = 1'b1;
                    grant_idx   = ID_W'(i);
                    grant_oh[i] = 1'b1;
                    grant_a     = req_a[i*D_WIDTH +: D_WIDTH];
                    grant_b     = req_b[i*D_WIDTH +: D_WIDTH];
                end
            end
        end
    end

    // While reset is asserted, nobody is accepted. This keeps req_ready at
    // its reset value even if a client holds req_valid high through reset.
    always_comb begin
        handshake = reset_n && credit_ok && grant_found;
        req_ready = handshake ? grant_oh : '0;
    end

    // Issue stage: capture the winner's operands and tag for next cycle.
    // The pointer then moves just past the winner so that it has lowest
    // priority next time.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        mul_valid_d = handshake;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        issue_id_d  = issue_id_q;
        if (handshake) begin
            mul_a_d    = grant_a;
            mul_b_d    = grant_b;
            issue_id_d = grant_idx;
            rr_ptr_d   = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    // Tag pipe: a MUL_LATENCY-deep shift register fed from the issue
    // register. Its last stage is valid in exactly the cycle that the
    // matching product appears on mul_result.
    always_comb begin
        tag_valid_d[0] = mul_valid_q;
        tag_id_d[0]    = issue_id_q;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_id_d[i]    = tag_id_q[i-1];
        end
    end

    // Response FIFO. A push comes from the tag-pipe output. A pop comes from
    // the consumer handshake. When both happen in one cycle, both pointers
    // advance and the count holds. Credit guarantees that a push never finds
    // the FIFO full.
    always_comb begin
        push         = tag_valid_q[MUL_LATENCY-1];
        pop          = (fifo_count_q != '0) && rsp_ready;
        fifo_data_d  = fifo_data_q;
        fifo_id_d    = fifo_id_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = mul_result;
            fifo_id_d[wr_ptr_q]   = tag_id_q[MUL_LATENCY-1];
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            fifo_count_d = fifo_count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            fifo_count_d = fifo_count_q - (PTR_W+1)'(1);
        end
    end

    // All state lives here. Reset clears the FIFO storage as well as the
    // pointers, so that rsp_id/rsp_data read back as zero after reset
    // instead of stale data from before it.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            rr_ptr_q     <= '0;
            mul_valid_q  <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            issue_id_q   <= '0;
            tag_valid_q  <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_id_q[i]   <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            mul_valid_q  <= mul_valid_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            issue_id_q   <= issue_id_d;
            tag_valid_q  <= tag_valid_d;
            tag_id_q     <= tag_id_d;
            fifo_data_q  <= fifo_data_d;
            fifo_id_q    <= fifo_id_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    assign mul_valid = mul_valid_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = (fifo_count_q != '0);
    assign rsp_id    = fifo_id_q[rd_ptr_q];
    assign rsp_data  = fifo_data_q[rd_ptr_q];
    assign busy      = (in_flight != '0) || (fifo_count_q != '0);

endmodule

// File: tb/tb_fpu_mul_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fpu_mul_scheduler
//
// Directed bench for fpu_mul_scheduler at default parameters.
// A behavioural 3-stage FP multiplier handles normal, exactly representable
// operands and sits on the multiplier side of the scheduler. Each test task
// drives its scenario and compares outputs against hand-computed values.
// Inputs change on the falling edge. Outputs are sampled 1 ns later, well
// away from the rising edge.
// ---------------------------------------------------------------------------
module tb_fpu_mul_scheduler;

    localparam logic [31:0] F1  = 32'h3F800000;
    localparam logic [31:0] F2  = 32'h40000000;
    localparam logic [31:0] F3  = 32'h40400000;
    localparam logic [31:0] F4  = 32'h40800000;
    localparam logic [31:0] F5  = 32'h40A00000;
    localparam logic [31:0] F6  = 32'h40C00000;
    localparam logic [31:0] F8  = 32'h41000000;
    localparam logic [31:0] F10 = 32'h41200000;

    logic         clk_in;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         mul_valid;
    logic [31:0]  mul_a;
    logic [31:0]  mul_b;
    logic [31:0]  mul_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
    logic         busy;

    int assert_count;
    int fail_count;

    fpu_mul_scheduler dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_valid  (mul_valid),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Converts a normal single-precision value to real by widening the
    // exponent. This is enough for the small exact operands used here.
    function automatic real sp2real(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
        real         p;
        logic [63:0] d;
        p = sp2real(x) * sp2real(y);
        if (p == 0.0) return 32'h0;
        d = $realtobits(p);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    // Multiplier stand-in. The product lands on mul_result three cycles
    // after mul_valid, and the stages clear on the shared reset.
    logic [31:0] mpipe [3];
    always @(posedge clk_in) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) mpipe[i] <= 32'h0;
        end else begin
            mpipe[0] <= mul_valid ? fmul(mul_a, mul_b) : 32'h0;
            mpipe[1] <= mpipe[0];
            mpipe[2] <= mpipe[1];
        end
    end
    assign mul_result = mpipe[2];

    task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b);
        req_a[r*32 +: 32] = a;
        req_b[r*32 +: 32] = b;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset_n   = 1'b0;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        @(negedge clk_in);
        reset_n = 1'b1;
    endtask

    // Every output must show its reset value after reset has been held for
    // two clocks.
    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        #1;
        assert_count++; if (req_ready !== 4'b0000) begin fail_count++; $display("[TB] FAIL reset_req_ready: got %b, expected 0000", req_ready); end
        assert_count++; if (mul_valid !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_mul_valid: got %b, expected 0", mul_valid); end
        assert_count++; if (mul_a !== 32'h0) begin fail_count++; $display("[TB] FAIL reset_mul_a: got %h, expected 0", mul_a); end
        assert_count++; if (mul_b !== 32'h0) begin fail_count++; $display("[TB] FAIL reset_mul_b: got %h, expected 0", mul_b); end
        assert_count++; if (rsp_valid !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_rsp_valid: got %b, expected 0", rsp_valid); end
        assert_count++; if (rsp_id !== 2'd0) begin fail_count++; $display("[TB] FAIL reset_rsp_id: got %0d, expected 0", rsp_id); end
        assert_count++; if (rsp_data !== 32'h0) begin fail_count++; $display("[TB] FAIL reset_rsp_data: got %h, expected 0", rsp_data); end
        assert_count++; if (busy !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        @(negedge clk_in);
        reset_n = 1'b1;
    endtask

    // 2.0 * 3.0 from requester 0. The operands issue one cycle after the
    // handshake, and the response becomes visible five cycles after it.
    task automatic test_single_op();
        int          first;
        logic [1:0]  cap_id;
        logic [31:0] cap_data;
        first    = -1;
        cap_id   = 'x;
        cap_data = 'x;
        @(negedge clk_in);
        set_op(0, F2, F3);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        assert_count++; if (req_ready !== 4'b0001) begin fail_count++; $display("[TB] FAIL single_ready: got %b, expected 0001", req_ready); end
        @(negedge clk_in);
        req_valid = 4'b0000;
        #1;
        assert_count++; if (mul_valid !== 1'b1) begin fail_count++; $display("[TB] FAIL single_mul_valid: got %b, expected 1", mul_valid); end
        assert_count++; if (mul_a !== F2) begin fail_count++; $display("[TB] FAIL single_mul_a: got %h, expected %h", mul_a, F2); end
        assert_count++; if (mul_b !== F3) begin fail_count++; $display("[TB] FAIL single_mul_b: got %h, expected %h", mul_b, F3); end
        assert_count++; if (busy !== 1'b1) begin fail_count++; $display("[TB] FAIL single_busy: got %b, expected 1", busy); end
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk_in);
            #1;
            if (rsp_valid === 1'b1 && first < 0) begin
                first    = k;
                cap_id   = rsp_id;
                cap_data = rsp_data;
            end
        end
        assert_count++; if (first != 5) begin fail_count++; $display("[TB] FAIL single_latency: got cycle %0d, expected 5", first); end
        assert_count++; if (cap_id !== 2'd0) begin fail_count++; $display("[TB] FAIL single_rsp_id: got %0d, expected 0", cap_id); end
        assert_count++; if (cap_data !== F6) begin fail_count++; $display("[TB] FAIL single_rsp_data: got %h, expected %h", cap_data, F6); end
        assert_count++; if (rsp_valid !== 1'b0) begin fail_count++; $display("[TB] FAIL single_drained: got %b, expected 0", rsp_valid); end
        assert_count++; if (busy !== 1'b0) begin fail_count++; $display("[TB] FAIL single_idle: got %b, expected 0", busy); end
    endtask

    // All four requesters stay valid. Grants rotate 0,1,2,3, and the credit
    // limit stalls for two cycles after every four issues. Responses must
    // come back in grant order with the right products.
    task automatic test_round_robin();
        logic [31:0] av    [4] = '{F1, F2, F3, F4};
        logic [31:0] prod  [4] = '{F2, F4, F6, F8};
        logic [3:0]  exp_r [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0001};
        int          grants[$];
        int          got_id[$];
        logic [31:0] got_d[$];
        do_reset();
        for (int r = 0; r < 4; r++) set_op(r, av[r], F2);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_in);
            req_valid = (k < 24) ? 4'b1111 : 4'b0000;
            rsp_ready = 1'b1;
            #1;
            if (k < 7) begin
                assert_count++; if (req_ready !== exp_r[k]) begin fail_count++; $display("[TB] FAIL rr_ready[%0d]: got %b, expected %b", k, req_ready, exp_r[k]); end
            end
            assert_count++; if (!$onehot0(req_ready)) begin fail_count++; $display("[TB] FAIL rr_onehot[%0d]: got %b, expected one-hot or zero", k, req_ready); end
            for (int i = 0; i < 4; i++) if (req_ready[i]) grants.push_back(i);
            if (rsp_valid && rsp_ready) begin
                got_id.push_back(int'(rsp_id));
                got_d.push_back(rsp_data);
            end
        end
        assert_count++; if (grants.size() != 16) begin fail_count++; $display("[TB] FAIL rr_grant_count: got %0d, expected 16", grants.size()); end
        for (int i = 0; i < grants.size(); i++) begin
            assert_count++; if (grants[i] != i % 4) begin fail_count++; $display("[TB] FAIL rr_grant[%0d]: got %0d, expected %0d", i, grants[i], i % 4); end
        end
        assert_count++; if (got_id.size() != 16) begin fail_count++; $display("[TB] FAIL rr_rsp_count: got %0d, expected 16", got_id.size()); end
        for (int i = 0; i < got_id.size(); i++) begin
            assert_count++; if (got_id[i] != i % 4) begin fail_count++; $display("[TB] FAIL rr_rsp_id[%0d]: got %0d, expected %0d", i, got_id[i], i % 4); end
            assert_count++; if (got_d[i] !== prod[i % 4]) begin fail_count++; $display("[TB] FAIL rr_rsp_data[%0d]: got %h, expected %h", i, got_d[i], prod[i % 4]); end
        end
    endtask

    // Requester 2 streams while the consumer stalls. Exactly four
    // operations fit. A single pop frees exactly one slot, and only from the
    // cycle after the pop.
    task automatic test_credit();
        logic [31:0] av   [5] = '{F1, F2, F3, F4, F5};
        logic [31:0] prod [5] = '{F2, F4, F6, F8, F10};
        int          n;
        int          m;
        int          got_id[$];
        logic [31:0] got_d[$];
        n = 0;
        m = 0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            set_op(2, av[(n < 5) ? n : 4], F2);
            req_valid = 4'b0100;
            rsp_ready = 1'b0;
            #1;
            if (req_ready[2]) n++;
        end
        assert_count++; if (n != 4) begin fail_count++; $display("[TB] FAIL credit_accepts: got %0d, expected 4", n); end
        assert_count++; if (req_ready !== 4'b0000) begin fail_count++; $display("[TB] FAIL credit_blocked: got %b, expected 0000", req_ready); end
        assert_count++; if (rsp_valid !== 1'b1) begin fail_count++; $display("[TB] FAIL credit_rsp_valid: got %b, expected 1", rsp_valid); end
        assert_count++; if (rsp_id !== 2'd2) begin fail_count++; $display("[TB] FAIL credit_rsp_id: got %0d, expected 2", rsp_id); end
        assert_count++; if (rsp_data !== F2) begin fail_count++; $display("[TB] FAIL credit_head: got %h, expected %h", rsp_data, F2); end
        @(negedge clk_in);
        rsp_ready = 1'b1;
        #1;
        assert_count++; if (req_ready !== 4'b0000) begin fail_count++; $display("[TB] FAIL credit_pop_same_cycle: got %b, expected 0000", req_ready); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            set_op(2, av[(n < 5) ? n : 4], F2);
            rsp_ready = 1'b0;
            #1;
            if (req_ready[2]) begin
                m++;
                n++;
            end
        end
        assert_count++; if (m != 1) begin fail_count++; $display("[TB] FAIL credit_one_more: got %0d, expected 1", m); end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            req_valid = 4'b0000;
            rsp_ready = 1'b1;
            #1;
            if (rsp_valid) begin
                got_id.push_back(int'(rsp_id));
                got_d.push_back(rsp_data);
            end
        end
        assert_count++; if (got_d.size() != 4) begin fail_count++; $display("[TB] FAIL credit_drain_count: got %0d, expected 4", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 4; i++) begin
            assert_count++; if (got_d[i] !== prod[i+1]) begin fail_count++; $display("[TB] FAIL credit_drain_data[%0d]: got %h, expected %h", i, got_d[i], prod[i+1]); end
            assert_count++; if (got_id[i] != 2) begin fail_count++; $display("[TB] FAIL credit_drain_id[%0d]: got %0d, expected 2", i, got_id[i]); end
        end
    endtask

    // Granting requester 2 moves rr_ptr to 3. Then a lone requester 1 must
    // win through the wrap, which leaves rr_ptr at 2. The third grant,
    // between requesters 1 and 2, shows that rr_ptr is now 2: pointers of
    // 0, 1 or 3 would all pick requester 1.
    task automatic test_wrap();
        logic [3:0] vin  [3] = '{4'b0100, 4'b0010, 4'b0110};
        logic [3:0] vexp [3] = '{4'b0100, 4'b0010, 4'b0100};
        int         exp_id [3] = '{2, 1, 2};
        int         got_id[$];
        do_reset();
        for (int r = 0; r < 4; r++) set_op(r, F3, F2);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk_in);
            req_valid = (k < 3) ? vin[k] : 4'b0000;
            rsp_ready = 1'b1;
            #1;
            if (k < 3) begin
                assert_count++; if (req_ready !== vexp[k]) begin fail_count++; $display("[TB] FAIL wrap_grant[%0d]: got %b, expected %b", k, req_ready, vexp[k]); end
            end
            if (rsp_valid) got_id.push_back(int'(rsp_id));
        end
        assert_count++; if (got_id.size() != 3) begin fail_count++; $display("[TB] FAIL wrap_rsp_count: got %0d, expected 3", got_id.size()); end
        for (int i = 0; i < got_id.size() && i < 3; i++) begin
            assert_count++; if (got_id[i] != exp_id[i]) begin fail_count++; $display("[TB] FAIL wrap_rsp_id[%0d]: got %0d, expected %0d", i, got_id[i], exp_id[i]); end
        end
    endtask

    // Four operations fill the credit. Three results are queued when the
    // fourth arrives, and a pop in that same cycle must leave three entries
    // in the original order.
    task automatic test_fifo_pushpop();
        logic [31:0] av   [4] = '{F1, F2, F3, F4};
        logic [31:0] prod [4] = '{F2, F4, F6, F8};
        logic [31:0] got_d[$];
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            set_op(0, av[k], F2);
            req_valid = 4'b0001;
            rsp_ready = 1'b0;
            #1;
            assert_count++; if (req_ready !== 4'b0001) begin fail_count++; $display("[TB] FAIL pp_accept[%0d]: got %b, expected 0001", k, req_ready); end
        end
        for (int k = 4; k < 7; k++) begin
            @(negedge clk_in);
            req_valid = 4'b0000;
            #1;
        end
        @(negedge clk_in);
        rsp_ready = 1'b1;
        #1;
        assert_count++; if (rsp_data !== prod[0]) begin fail_count++; $display("[TB] FAIL pp_head_before: got %h, expected %h", rsp_data, prod[0]); end
        @(negedge clk_in);
        rsp_ready = 1'b0;
        #1;
        assert_count++; if (rsp_data !== prod[1]) begin fail_count++; $display("[TB] FAIL pp_head_after: got %h, expected %h", rsp_data, prod[1]); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            rsp_ready = 1'b1;
            #1;
            if (rsp_valid) got_d.push_back(rsp_data);
        end
        assert_count++; if (got_d.size() != 3) begin fail_count++; $display("[TB] FAIL pp_count: got %0d, expected 3", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 3; i++) begin
            assert_count++; if (got_d[i] !== prod[i+1]) begin fail_count++; $display("[TB] FAIL pp_order[%0d]: got %h, expected %h", i, got_d[i], prod[i+1]); end
        end
    endtask

    // A one-cycle reset with three operations in flight must wipe
    // everything. No response should appear afterwards.
    task automatic test_reset_mid();
        int seen;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            set_op(3, F3, F2);
            req_valid = 4'b1000;
            rsp_ready = 1'b0;
            #1;
            assert_count++; if (req_ready !== 4'b1000) begin fail_count++; $display("[TB] FAIL rm_accept[%0d]: got %b, expected 1000", k, req_ready); end
        end
        @(negedge clk_in);
        req_valid = 4'b0000;
        reset_n   = 1'b0;
        #1;
        assert_count++; if (busy !== 1'b1) begin fail_count++; $display("[TB] FAIL rm_busy_before: got %b, expected 1", busy); end
        @(negedge clk_in);
        reset_n = 1'b1;
        #1;
        assert_count++; if (req_ready !== 4'b0000) begin fail_count++; $display("[TB] FAIL rm_req_ready: got %b, expected 0000", req_ready); end
        assert_count++; if (mul_valid !== 1'b0) begin fail_count++; $display("[TB] FAIL rm_mul_valid: got %b, expected 0", mul_valid); end
        assert_count++; if (mul_a !== 32'h0) begin fail_count++; $display("[TB] FAIL rm_mul_a: got %h, expected 0", mul_a); end
        assert_count++; if (mul_b !== 32'h0) begin fail_count++; $display("[TB] FAIL rm_mul_b: got %h, expected 0", mul_b); end
        assert_count++; if (rsp_valid !== 1'b0) begin fail_count++; $display("[TB] FAIL rm_rsp_valid: got %b, expected 0", rsp_valid); end
        assert_count++; if (rsp_id !== 2'd0) begin fail_count++; $display("[TB] FAIL rm_rsp_id: got %0d, expected 0", rsp_id); end
        assert_count++; if (rsp_data !== 32'h0) begin fail_count++; $display("[TB] FAIL rm_rsp_data: got %h, expected 0", rsp_data); end
        assert_count++; if (busy !== 1'b0) begin fail_count++; $display("[TB] FAIL rm_busy: got %b, expected 0", busy); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            rsp_ready = 1'b1;
            #1;
            if (rsp_valid !== 1'b0) seen++;
        end
        assert_count++; if (seen != 0) begin fail_count++; $display("[TB] FAIL rm_stale_rsp: got %0d valid cycles, expected 0", seen); end
    endtask

    // Test sequence. Each task leaves the scheduler idle for the next one.
    initial begin
        assert_count = 0;
        fail_count   = 0;
        reset_n      = 1'b0;
        req_valid    = 4'b0000;
        rsp_ready    = 1'b0;
        req_a        = '0;
        req_b        = '0;
        $display("[TB] starting fpu_mul_scheduler bench");
        test_reset();
        test_single_op();
        test_round_robin();
        test_credit();
        test_wrap();
        test_fifo_pushpop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
